// File: rtl/pad_ctrl_pkg.sv
// rtl/pad_ctrl_pkg.sv - config field layout and shared types for bidir_pad_ctrl
package pad_ctrl_pkg;

    localparam int CFG_W         = 10;
    localparam int BIT_GPIO_MODE = 0;
    localparam int BIT_GPIO_OUT  = 1;
    localparam int BIT_GPIO_OE   = 2;
    localparam int BIT_CS        = 3;
    localparam int BIT_SL        = 4;
    localparam int BIT_IE        = 5;
    localparam int BIT_PU        = 6;
    localparam int BIT_PD        = 7;
    localparam int BIT_RISE_EN   = 8;
    localparam int BIT_FALL_EN   = 9;
    localparam int BIT_SYNC      = 16;
    localparam int BIT_RISE_PEND = 17;
    localparam int BIT_FALL_PEND = 18;

    // Members listed high bit first so struct bit n equals register bit n.
    typedef struct packed {
        logic fall_en;
        logic rise_en;
        logic pd;
        logic pu;
        logic ie;
        logic sl;
        logic cs;
        logic gpio_oe;
        logic gpio_out;
        logic gpio_mode;
    } pad_cfg_t;

    localparam pad_cfg_t PAD_CFG_RST = pad_cfg_t'(10'h020);

    function automatic logic [31:0] status_word(input pad_cfg_t cfg, input logic sync,
                                                input logic rise_pend, input logic fall_pend);
        logic [31:0] w;
        w                = '0;
        w[CFG_W-1:0]     = cfg;
        w[BIT_SYNC]      = sync;
        w[BIT_RISE_PEND] = rise_pend;
        w[BIT_FALL_PEND] = fall_pend;
        return w;
    endfunction

endpackage

// File: rtl/pad_in_sync.sv
// rtl/pad_in_sync.sv - two-flop pad input synchroniser with rise/fall pulse detection
module pad_in_sync #(
    parameter int N = 54
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    output logic [N-1:0] sync,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    logic [N-1:0] meta;
    logic [N-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/bidir_pad_ctrl.sv
// rtl/bidir_pad_ctrl.sv - per-pin pad mux, config registers and edge interrupts
module bidir_pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int NUM_BIDIR = 54,
    parameter int ADDR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    input  logic [NUM_BIDIR-1:0] func_out,
    input  logic [NUM_BIDIR-1:0] func_oe,
    output logic [NUM_BIDIR-1:0] sync_in,
    output logic                 irq,
    input  logic [NUM_BIDIR-1:0] bidir_in,
    output logic [NUM_BIDIR-1:0] bidir_out,
    output logic [NUM_BIDIR-1:0] bidir_oe,
    output logic [NUM_BIDIR-1:0] bidir_cs,
    output logic [NUM_BIDIR-1:0] bidir_sl,
    output logic [NUM_BIDIR-1:0] bidir_ie,
    output logic [NUM_BIDIR-1:0] bidir_pu,
    output logic [NUM_BIDIR-1:0] bidir_pd
);

    pad_cfg_t             cfg [NUM_BIDIR];
    logic [NUM_BIDIR-1:0] rise_pend, fall_pend;
    logic [NUM_BIDIR-1:0] rise, fall;
    logic [NUM_BIDIR-1:0] addr_sel, wr_sel, rise_clr, fall_clr;
    logic [NUM_BIDIR-1:0] rise_en, fall_en;
    logic [NUM_BIDIR-1:0] out_d, oe_d, cs_d, sl_d, ie_d, pu_d, pd_d;
    logic [31:0]          rd_word;
    logic                 accept;
    logic                 unused_wdata;

    assign unused_wdata = ^{req_wdata[31:19], req_wdata[15:CFG_W]};

    pad_in_sync #(.N(NUM_BIDIR)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bidir_in),
        .sync (sync_in),
        .rise (rise),
        .fall (fall)
    );

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Address decode and read mux; out-of-range addresses select nothing and read 0.
    always_comb begin
        addr_sel = '0;
        rd_word  = '0;
        for (int i = 0; i < NUM_BIDIR; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                addr_sel[i] = 1'b1;
                rd_word     = status_word(cfg[i], sync_in[i], rise_pend[i], fall_pend[i]);
            end
        end
    end

    assign wr_sel   = addr_sel & {NUM_BIDIR{accept && req_we}};
    assign rise_clr = wr_sel & {NUM_BIDIR{req_wdata[BIT_RISE_PEND]}};
    assign fall_clr = wr_sel & {NUM_BIDIR{req_wdata[BIT_FALL_PEND]}};

    always_comb begin
        out_d   = '0;
        oe_d    = '0;
        cs_d    = '0;
        sl_d    = '0;
        ie_d    = '0;
        pu_d    = '0;
        pd_d    = '0;
        rise_en = '0;
        fall_en = '0;
        for (int i = 0; i < NUM_BIDIR; i++) begin
            out_d[i]   = cfg[i].gpio_mode ? cfg[i].gpio_out : func_out[i];
            oe_d[i]    = cfg[i].gpio_mode ? cfg[i].gpio_oe  : func_oe[i];
            cs_d[i]    = cfg[i].cs;
            sl_d[i]    = cfg[i].sl;
            ie_d[i]    = cfg[i].ie;
            pu_d[i]    = cfg[i].pu;
            pd_d[i]    = cfg[i].pd && !cfg[i].pu;
            rise_en[i] = cfg[i].rise_en;
            fall_en[i] = cfg[i].fall_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
                cfg[i] <= PAD_CFG_RST;
            end
        end else begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
                if (wr_sel[i]) begin
                    cfg[i] <= pad_cfg_t'(req_wdata[CFG_W-1:0]);
                end
            end
        end
    end

    // Edge set takes priority over a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pend <= '0;
            fall_pend <= '0;
            irq       <= 1'b0;
        end else begin
            rise_pend <= (rise_pend & ~rise_clr) | (rise & rise_en);
            fall_pend <= (fall_pend & ~fall_clr) | (fall & fall_en);
            irq       <= |{rise_pend, fall_pend};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_we ? 32'h0 : rd_word;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bidir_out <= '0;
            bidir_oe  <= '0;
            bidir_cs  <= '0;
            bidir_sl  <= '0;
            bidir_ie  <= '1;
            bidir_pu  <= '0;
            bidir_pd  <= '0;
        end else begin
            bidir_out <= out_d;
            bidir_oe  <= oe_d;
            bidir_cs  <= cs_d;
            bidir_sl  <= sl_d;
            bidir_ie  <= ie_d;
            bidir_pu  <= pu_d;
            bidir_pd  <= pd_d;
        end
    end

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// tb/tb_bidir_pad_ctrl.sv - self-checking bench for bidir_pad_ctrl
module tb_bidir_pad_ctrl;

    localparam int N = 54;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [7:0]   req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [31:0]  rsp_rdata;
    logic [N-1:0] func_out = '0;
    logic [N-1:0] func_oe = '0;
    logic [N-1:0] sync_in;
    logic         irq;
    logic [N-1:0] bidir_in = '0;
    logic [N-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

    logic [9:0]   m_cfg [N];
    logic [N-1:0] m_rpend, m_fpend, m_in;
    int           checks = 0;
    int           failures = 0;

    bidir_pad_ctrl #(.NUM_BIDIR(N), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .func_out(func_out), .func_oe(func_oe), .sync_in(sync_in), .irq(irq),
        .bidir_in(bidir_in), .bidir_out(bidir_out), .bidir_oe(bidir_oe),
        .bidir_cs(bidir_cs), .bidir_sl(bidir_sl), .bidir_ie(bidir_ie),
        .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cfg[i] = 10'h020;
        m_rpend = '0;
        m_fpend = '0;
    endfunction

    function automatic logic [31:0] exp_word(input int p);
        logic [31:0] w;
        w       = '0;
        w[9:0]  = m_cfg[p];
        w[16]   = m_in[p];
        w[17]   = m_rpend[p];
        w[18]   = m_fpend[p];
        return w;
    endfunction

    // Expected pad vector for field f: 0 out, 1 oe, 2 cs, 3 sl, 4 ie, 5 pu, 6 pd.
    function automatic logic [N-1:0] exp_vec(input int f);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            case (f)
                0: v[i] = m_cfg[i][0] ? m_cfg[i][1] : func_out[i];
                1: v[i] = m_cfg[i][0] ? m_cfg[i][2] : func_oe[i];
                2: v[i] = m_cfg[i][3];
                3: v[i] = m_cfg[i][4];
                4: v[i] = m_cfg[i][5];
                5: v[i] = m_cfg[i][6];
                6: v[i] = m_cfg[i][7] && !m_cfg[i][6];
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    task automatic bus_access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL bus_rsp_valid addr=%0d: got %b expected 1", addr, rsp_valid);
        end
        rdata = rsp_rdata;
    endtask

    task automatic compare_pads(input string tag);
        logic [N-1:0] act [7];
        act = '{bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd};
        for (int f = 0; f < 7; f++) begin
            checks++;
            if (act[f] !== exp_vec(f)) begin
                failures++;
                $display("FAIL %s field%0d: got %h expected %h", tag, f, act[f], exp_vec(f));
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        model_reset();
        m_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bidir_ie !== {N{1'b1}}) begin
            failures++; $display("FAIL reset_ie: got %h expected all ones", bidir_ie);
        end
        checks++;
        if ({bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_pu, bidir_pd} !== '0) begin
            failures++; $display("FAIL reset_pads: got nonzero expected 0");
        end
        checks++;
        if (irq !== 1'b0 || sync_in !== '0) begin
            failures++; $display("FAIL reset_irq_sync: got irq=%b sync=%h expected 0", irq, sync_in);
        end
        bus_access(1'b0, 8'd5, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0020) begin
            failures++; $display("FAIL reset_read5: got %h expected 00000020", rd);
        end
    endtask

    task automatic test_func_to_gpio();
        logic [31:0] rd;
        func_out = '0; func_oe = '0;
        func_out[3] = 1'b1; func_oe[3] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bidir_out[3] !== 1'b1 || bidir_oe[3] !== 1'b1) begin
            failures++; $display("FAIL func_pin3: got out=%b oe=%b expected 1 1", bidir_out[3], bidir_oe[3]);
        end
        for (int k = 0; k < 4; k++) begin
            func_out = N'({$urandom(), $urandom()});
            func_oe  = N'({$urandom(), $urandom()});
            @(posedge clk); #1;
            compare_pads("func_random");
        end
        func_out[3] = 1'b1; func_oe[3] = 1'b1;
        bus_access(1'b1, 8'd3, 32'h001, rd);
        m_cfg[3] = 10'h001;
        @(posedge clk); #1;
        checks++;
        if (bidir_out[3] !== 1'b0 || bidir_oe[3] !== 1'b0) begin
            failures++; $display("FAIL gpio_pin3: got out=%b oe=%b expected 0 0", bidir_out[3], bidir_oe[3]);
        end
    endtask

    task automatic test_gpio_random();
        logic [31:0] rd;
        int          p;
        logic [9:0]  w;
        for (int k = 0; k < 24; k++) begin
            p = $urandom_range(N - 1);
            w = 10'($urandom_range(1023));
            func_out = N'({$urandom(), $urandom()});
            func_oe  = N'({$urandom(), $urandom()});
            bus_access(1'b1, 8'(p), {22'b0, w}, rd);
            m_cfg[p] = w;
            checks++;
            if (rd !== 32'h0) begin
                failures++; $display("FAIL write_rdata: got %h expected 0", rd);
            end
            @(posedge clk); #1;
            compare_pads("gpio_random");
            bus_access(1'b0, 8'(p), 32'h0, rd);
            checks++;
            if (rd !== exp_word(p)) begin
                failures++; $display("FAIL readback pin%0d: got %h expected %h", p, rd, exp_word(p));
            end
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        bus_access(1'b1, 8'd7, 32'h100, rd);
        m_cfg[7] = 10'h100;
        bidir_in[7] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sync_in[7] !== 1'b0) begin
            failures++; $display("FAIL sync_lat1: got %b expected 0", sync_in[7]);
        end
        @(posedge clk); #1;
        checks++;
        if (sync_in[7] !== 1'b1) begin
            failures++; $display("FAIL sync_lat2: got %b expected 1", sync_in[7]);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_early: got %b expected 0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_set: got %b expected 1", irq);
        end
        m_in[7] = 1'b1;
        m_rpend[7] = 1'b1;
        bus_access(1'b0, 8'd7, 32'h0, rd);
        checks++;
        if (rd !== 32'h0003_0100) begin
            failures++; $display("FAIL rise_status: got %h expected 00030100", rd);
        end
        bus_access(1'b1, 8'd7, 32'h0002_0100, rd);
        m_rpend[7] = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_hold: got %b expected 1", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_w1c: got %b expected 0", irq);
        end
        bidir_in[7] = 1'b0;
        m_in[7] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus_access(1'b0, 8'd7, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0100 || irq !== 1'b0) begin
            failures++; $display("FAIL fall_disabled: got %h irq=%b expected 00000100 irq=0", rd, irq);
        end
    endtask

    task automatic test_edge_random();
        logic [31:0]  rd;
        logic [N-1:0] nv;
        int           p;
        for (int k = 0; k < 10; k++) begin
            p = $urandom_range(N - 1);
            m_cfg[p] = (m_cfg[p] & 10'h0FF) | 10'({$urandom_range(3)} << 8);
            bus_access(1'b1, 8'(p), {22'b0, m_cfg[p]}, rd);
        end
        for (int v = 0; v < 6; v++) begin
            nv = N'({$urandom(), $urandom()});
            bidir_in = nv;
            for (int i = 0; i < N; i++) begin
                if (nv[i] && !m_in[i] && m_cfg[i][8]) m_rpend[i] = 1'b1;
                if (!nv[i] && m_in[i] && m_cfg[i][9]) m_fpend[i] = 1'b1;
            end
            m_in = nv;
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (sync_in !== m_in) begin
                failures++; $display("FAIL sync_random: got %h expected %h", sync_in, m_in);
            end
            checks++;
            if (irq !== (|{m_rpend, m_fpend})) begin
                failures++; $display("FAIL irq_random: got %b expected %b", irq, |{m_rpend, m_fpend});
            end
        end
        for (int i = 0; i < N; i++) begin
            bus_access(1'b0, 8'(i), 32'h0, rd);
            checks++;
            if (rd !== exp_word(i)) begin
                failures++; $display("FAIL status pin%0d: got %h expected %h", i, rd, exp_word(i));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_rpend[i] || m_fpend[i]) begin
                bus_access(1'b1, 8'(i), {22'b0, m_cfg[i]} | 32'h0006_0000, rd);
            end
        end
        m_rpend = '0;
        m_fpend = '0;
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_cleared: got %b expected 0", irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, e1, e2;
        bus_access(1'b1, 8'd2, 32'h2A5, rd);
        m_cfg[2] = 10'h2A5;
        bus_access(1'b1, 8'd9, 32'h15A, rd);
        m_cfg[9] = 10'h15A;
        @(posedge clk); #1;
        e1 = exp_word(2);
        e2 = exp_word(9);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd2;
        @(posedge clk); #1;
        req_addr = 8'd9;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d: got valid=%b rdata=%h ready=%b expected 1 %h 0",
                         k, rsp_valid, rsp_rdata, req_ready, e1);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL ready_release: got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e2) begin
            failures++; $display("FAIL second_rsp: got valid=%b rdata=%h expected 1 %h", rsp_valid, rsp_rdata, e2);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rsp_drain: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_range_and_pull();
        logic [31:0] rd;
        bus_access(1'b0, 8'd60, 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL read_oor: got %h expected 0", rd);
        end
        bus_access(1'b1, 8'd60, 32'h3FF, rd);
        @(posedge clk); #1;
        compare_pads("write_oor");
        bus_access(1'b1, 8'd0, 32'h0C0, rd);
        m_cfg[0] = 10'h0C0;
        @(posedge clk); #1;
        checks++;
        if (bidir_pu[0] !== 1'b1 || bidir_pd[0] !== 1'b0) begin
            failures++; $display("FAIL pull_priority: got pu=%b pd=%b expected 1 0", bidir_pu[0], bidir_pd[0]);
        end
        bus_access(1'b0, 8'd0, 32'h0, rd);
        checks++;
        if (rd !== exp_word(0)) begin
            failures++; $display("FAIL pull_readback: got %h expected %h", rd, exp_word(0));
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++; $display("FAIL mid_read_valid: got %b expected 1", rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || irq !== 1'b0 || sync_in !== '0) begin
            failures++; $display("FAIL async_rst_bus: got valid=%b irq=%b sync=%h expected 0", rsp_valid, irq, sync_in);
        end
        checks++;
        if (bidir_ie !== {N{1'b1}} ||
            {bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_pu, bidir_pd} !== '0) begin
            failures++; $display("FAIL async_rst_pads: got ie=%h pu=%h expected reset values", bidir_ie, bidir_pu);
        end
        repeat (2) @(posedge clk);
        #1;
        bidir_in = '0;
        func_out = '0;
        func_oe  = '0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        model_reset();
        m_in = '0;
        repeat (3) @(posedge clk);
        #1;
        compare_pads("post_reset");
        bus_access(1'b0, 8'd0, 32'h0, rd);
        checks++;
        if (rd !== 32'h0000_0020) begin
            failures++; $display("FAIL post_reset_read: got %h expected 00000020", rd);
        end
    endtask

    initial begin
        test_reset();
        test_func_to_gpio();
        test_gpio_random();
        test_edge_irq();
        test_edge_random();
        test_back_to_back();
        test_range_and_pull();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bidir_pad_ctrl.md
Name: bidir_pad_ctrl

Overview:
Core-side controller placed between the chip_core functional logic and the unified bidirectional pad ring. It muxes functional outputs and GPIO register values onto each pad, and registers the per-pad OE/CS/SL/IE/PU/PD controls. It synchronises pad inputs and detects edges for interrupts. A simple valid/ready register bus gives software per-pin configuration and status.

Parameters:
NUM_BIDIR, 54, number of bidirectional pads controlled (1..64)
ADDR_W, 8, register bus address width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  register request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  pin index (word address)
req_wdata  in  32  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  32  read data (0 for writes)
func_out  in  NUM_BIDIR  functional output value per pin
func_oe  in  NUM_BIDIR  functional output enable per pin
sync_in  out  NUM_BIDIR  synchronised pad input to core
irq  out  1  OR of all pending edge flags
bidir_in  in  NUM_BIDIR  raw pad input (Y)
bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  out  NUM_BIDIR each  registered pad controls

Behaviour:
- Per-pin config register at address i (i < NUM_BIDIR). Bits: [0] gpio_mode, [1] gpio_out, [2] gpio_oe, [3] cs, [4] sl, [5] ie, [6] pu, [7] pd, [8] rise_en, [9] fall_en. Read-only: [16] sync_in[i], [17] rise_pend, [18] fall_pend. Writing 1 to bit 17 or 18 clears that flag (W1C). Other bits read 0.
- Config reset: all 0 except ie=1 for every pin. Pending flags reset to 0.
- Pad outputs are registered, 1-cycle latency. gpio_mode=0: bidir_out<=func_out, bidir_oe<=func_oe. gpio_mode=1: bidir_out<=gpio_out, bidir_oe<=gpio_oe.
- cs/sl/ie/pu/pd come from config regardless of mode.
- If pu and pd are both written 1, pd is forced to 0 (pull-up wins); readback shows the stored value.
- Pad output reset values: out=0, oe=0, cs=0, sl=0, ie=1, pu=0, pd=0.
- Input path: two-flop synchroniser per pin (reset 0), then a third "previous" flop for edge detection.
  - sync_in = second stage. Latency from bidir_in to sync_in is 2 clocks.
  - Rising edge = sync & ~prev; falling edge = ~sync & prev.
  - Pending flag sets on an edge when its enable bit is 1. If an edge and a W1C hit the same cycle, set wins.
- irq is registered: OR of all pending flags, 1 cycle after a flag changes.
- Bus protocol:
  - A request is accepted when req_valid && req_ready.
  - rsp_valid rises the cycle after acceptance and holds, with rsp_rdata stable, until rsp_valid && rsp_ready.
  - req_ready = !rsp_valid || rsp_ready, which allows back-to-back accesses at one per cycle.
  - A write takes effect on the pad registers one cycle after acceptance.
  - A read samples state at acceptance.
- Out-of-range address (>= NUM_BIDIR): write ignored, read returns 0, response still given.
- Reset asserted mid-transaction: the transaction is dropped, rsp_valid=0, and all registers return to reset values immediately (asynchronous).

Decomposition:
- Package pad_ctrl_pkg holds:
  - localparam bit indices for the config fields;
  - pad_cfg_t packed struct {gpio_mode, gpio_out, gpio_oe, cs, sl, ie, pu, pd, rise_en, fall_en};
  - PAD_CFG_RST constant.
- One sub-module, pad_in_sync: 2FF synchroniser, prev flop, rise/fall pulses, vectorised over NUM_BIDIR.

Test Plan:
- Reset with rst_n=0 for 3 cycles, then release -> every bidir_ie=1, all other pad outputs 0, irq=0, read of addr 5 returns 0x00000020.
- Drive func_out[3]=1, func_oe[3]=1 -> bidir_out[3]=1 and bidir_oe[3]=1 one cycle later. Then write addr 3 = 0x001 (gpio_mode, gpio_out=0) -> bidir_out[3]=0, bidir_oe[3]=0 the cycle after the write.
- Write addr 7 = 0x100, then toggle bidir_in[7] 0->1 -> sync_in[7]=1 after 2 cycles, irq=1 one cycle after the flag sets, read returns 0x00030100. Write 0x20100 (W1C) -> irq=0.
- Hold rsp_ready=0 with two requests queued -> req_ready=0 and rsp_rdata stable. Release rsp_ready -> second response arrives on the next cycle.
- Read addr 60 -> rsp_rdata=0. Write addr 0 = 0xC0 (pu=pd=1) -> bidir_pu[0]=1, bidir_pd[0]=0.
- Assert rst_n mid-read (rsp_valid=1) -> rsp_valid=0 and pad outputs at reset values in the same cycle.
